// File: rtl/comparator_pkg.sv
// Shared types and result encodings for the comparator family.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } cmp_state_t;

    // One-hot result word, ordered {gt, lt, eq}.
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

endpackage

// File: rtl/comparator_bit_cell.sv
// One-bit magnitude cell: flags a differing bit and which side holds the one.
module comparator_bit_cell (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic gt
);

    assign diff = a ^ b;
    assign gt   = a & ~b;

endmodule

// File: rtl/serial_comparator.sv
// MSB-first bit-serial unsigned comparator with early exit on the first
// differing bit and valid/ready handshakes on both sides.
module serial_comparator
    import comparator_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         A_gt_B,
    output logic         A_lt_B,
    output logic         A_eq_B,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    cmp_state_t      state;
    logic [N-1:0]    sa;
    logic [N-1:0]    sb;
    logic [CW-1:0]   cnt;
    logic [2:0]      result;
    logic            msb_diff;
    logic            msb_gt;

    comparator_bit_cell u_msb_cell (
        .a    (sa[N-1]),
        .b    (sb[N-1]),
        .diff (msb_diff),
        .gt   (msb_gt)
    );

    // NOTE: sa, sb and cnt are deliberately left out of the reset branch; they
    // are always reloaded on accept, so only control state and flags need it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa     <= A;
                        sb     <= B;
                        cnt    <= CW'(N - 1);
                        result <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (msb_diff) begin
                        result <= msb_gt ? CMP_GT : CMP_LT;
                        state  <= DONE;
                    end else if (cnt == '0) begin
                        result <= CMP_EQ;
                        state  <= DONE;
                    end else begin
                        sa  <= sa << 1;
                        sb  <= sb << 1;
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake strobes come straight off the state register; in_ready is
    // additionally held low for as long as reset is asserted.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign A_gt_B = result[2];
    assign A_lt_B = result[1];
    assign A_eq_B = result[0];

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: directed table, random pairs against an
// arithmetic model, backpressure, mid-compare reset and an N=1 build.
module tb_serial_comparator;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0] a8, b8;
    logic       gt8, lt8, eq8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [0:0] a1, b1;
    logic       gt1, lt1, eq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_comparator #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .A_gt_B(gt8), .A_lt_B(lt8), .A_eq_B(eq8), .busy(busy8)
    );

    serial_comparator #(.N(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .A(a1), .B(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .A_gt_B(gt1), .A_lt_B(lt1), .A_eq_B(eq1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned compare; latency from the top differing bit.
    function automatic void model8(input int a, input int b, output logic [2:0] fl, output int k);
        if (a > b)      fl = 3'b100;
        else if (a < b) fl = 3'b010;
        else            fl = 3'b001;
        k = (a == b) ? 8 : 8 - ($clog2((a ^ b) + 1) - 1);
    endfunction

    function automatic logic [2:0] flags8();
        return {gt8, lt8, eq8};
    endfunction

    // Accept a pair, measure latency, optionally poke in_valid while busy and
    // hold the result under backpressure, then consume it.
    task automatic cmp8(input logic [7:0] a, input logic [7:0] b, input bit pulse,
                        input int hold, input logic [2:0] exp_fl,
                        output int lat, output logic [2:0] fl);
        a8 = a; b8 = b; in_valid8 = 1'b1;
        check("accept_ready", in_ready8, 1);
        @(posedge clk); @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            if (pulse && lat == 1) begin
                a8 = 8'hFF; b8 = 8'h00; in_valid8 = 1'b1;
                check("shift_ready_low", in_ready8, 0);
            end
            @(posedge clk); lat++; @(negedge clk);
            in_valid8 = 1'b0;
        end
        fl = flags8();
        repeat (hold) begin
            if (pulse) begin
                in_valid8 = 1'b1;
                check("done_ready_low", in_ready8, 0);
            end
            @(posedge clk); @(negedge clk);
            in_valid8 = 1'b0;
            check("hold_valid", out_valid8, 1);
            check("hold_flags", flags8(), exp_fl);
        end
        out_ready8 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready8 = 1'b0;
        check("consumed_valid", out_valid8, 0);
        check("consumed_ready", in_ready8, 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] fl;
        int         lat;
    } vec8_t;

    typedef struct {
        logic       a;
        logic       b;
        logic [2:0] fl;
    } vec1_t;

    initial begin
        vec8_t      tab8 [7];
        vec1_t      tab1 [4];
        int         lat, exp_lat, any_valid;
        logic [2:0] fl, exp_fl;
        logic [7:0] ra, rb;
        int         hits [$];

        tab8[0] = '{8'h80, 8'h7F, 3'b100, 1};
        tab8[1] = '{8'h12, 8'h13, 3'b010, 8};
        tab8[2] = '{8'hA5, 8'hA5, 3'b001, 8};
        tab8[3] = '{8'h00, 8'h00, 3'b001, 8};
        tab8[4] = '{8'hFF, 8'hFF, 3'b001, 8};
        tab8[5] = '{8'h05, 8'h09, 3'b010, 5};
        tab8[6] = '{8'h01, 8'h00, 3'b100, 8};

        tab1[0] = '{1'b0, 1'b0, 3'b001};
        tab1[1] = '{1'b0, 1'b1, 3'b010};
        tab1[2] = '{1'b1, 1'b0, 3'b100};
        tab1[3] = '{1'b1, 1'b1, 3'b001};

        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready8, 0);
        check("rst_out_valid", out_valid8, 0);
        check("rst_busy", busy8, 0);
        check("rst_flags", flags8(), 3'b000);
        check("rst_in_ready_n1", in_ready1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready8, 1);
        check("post_rst_busy", busy8, 0);

        foreach (tab8[i]) begin
            cmp8(tab8[i].a, tab8[i].b, 1'b0, 0, tab8[i].fl, lat, fl);
            check($sformatf("tab_lat_%0d", i), lat, tab8[i].lat);
            check($sformatf("tab_flags_%0d", i), fl, tab8[i].fl);
        end

        // Backpressure with stray in_valid pulses during SHIFT and DONE.
        cmp8(8'h12, 8'h13, 1'b1, 5, 3'b010, lat, fl);
        check("bp_lat", lat, 8);
        check("bp_flags", fl, 3'b010);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = (i % 5 == 0) ? ra : 8'($urandom);
            model8(int'(ra), int'(rb), exp_fl, exp_lat);
            cmp8(ra, rb, 1'b0, i % 3, exp_fl, lat, fl);
            check("rand_lat", lat, exp_lat);
            check("rand_flags", fl, exp_fl);
        end

        // Reset during the third SHIFT cycle of a long compare.
        a8 = 8'h01; b8 = 8'h00; in_valid8 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
        end
        check("pre_reset_busy", busy8, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("abort_busy", busy8, 0);
        check("abort_out_valid", out_valid8, 0);
        check("abort_flags", flags8(), 3'b000);
        check("abort_in_ready", in_ready8, 0);
        rst = 1'b0;
        any_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid8) any_valid = 1;
        end
        check("abort_no_result", any_valid, 0);
        cmp8(8'h05, 8'h09, 1'b0, 0, 3'b010, lat, fl);
        check("after_abort_lat", lat, 5);
        check("after_abort_flags", fl, 3'b010);

        // N=1 build, out_ready tied high.
        foreach (tab1[i]) begin
            a1 = tab1[i].a; b1 = tab1[i].b; in_valid1 = 1'b1;
            check("n1_ready", in_ready1, 1);
            @(posedge clk); @(negedge clk);
            in_valid1 = 1'b0;
            @(posedge clk); @(negedge clk);
            check($sformatf("n1_valid_%0d", i), out_valid1, 1);
            check($sformatf("n1_flags_%0d", i), {gt1, lt1, eq1}, tab1[i].fl);
            @(posedge clk); @(negedge clk);
            check($sformatf("n1_valid_drop_%0d", i), out_valid1, 0);
        end

        // Back-to-back issue: one result every 3 cycles.
        in_valid1 = 1'b1;
        for (int c = 0; c < 15; c++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            @(posedge clk); @(negedge clk);
            if (out_valid1) hits.push_back(c);
        end
        in_valid1 = 1'b0;
        check("n1_b2b_count", hits.size(), 5);
        for (int i = 1; i < hits.size(); i++)
            check("n1_b2b_gap", hits[i] - hits[i-1], 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
# serial_comparator

- Multi-cycle, MSB-first bit-serial magnitude comparator for the datapath comparator family.
- Accepts an N-bit operand pair over a valid/ready input handshake and compares one bit per cycle, exiting early at the first differing bit.
- Returns a one-hot A_gt_B / A_lt_B / A_eq_B result over a valid/ready output handshake.
- Replaces the single-cycle parallel comparator where timing or area forbids an N-bit wide compare.

## Interface
- N, default 8: operand width, N >= 1.
- clk  input  1  rising-edge clock; the only clock domain.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair present on A, B.
- in_ready  output  1  block can accept an operand pair.
- A  input  N  first operand, unsigned.
- B  input  N  second operand, unsigned.
- out_valid  output  1  result flags valid.
- out_ready  input  1  consumer accepts the result.
- A_gt_B  output  1  A > B.
- A_lt_B  output  1  A < B.
- A_eq_B  output  1  A == B.
- busy  output  1  a compare is in progress (SHIFT or DONE state).

## Operation
- There is one clock. Reset is synchronous and active-high.
- Unsigned magnitude compare. Shift registers sa and sb are N bits wide. The bit counter is max(1,$clog2(N)) bits wide.
- State IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load sa <= A and sb <= B, load cnt <= N-1, clear all three flags, go to SHIFT.
- State SHIFT: each cycle, examine sa[N-1] vs sb[N-1].
  - Bits differ: A_gt_B <= sa[N-1], A_lt_B <= sb[N-1], go to DONE (early exit).
  - Bits equal and cnt == 0: A_eq_B <= 1, go to DONE.
  - Bits equal and cnt != 0: shift sa and sb left by 1, cnt <= cnt-1, stay in SHIFT.
- State DONE:
  - out_valid = 1. Flags are held stable.
  - On out_ready: go to IDLE. Flags keep their value but are don't-care while out_valid = 0.
- in_ready is low in SHIFT and DONE. A new pair cannot be accepted in the same cycle a result is consumed.
- While out_valid = 1, exactly one flag is high.
- A, B and in_valid are ignored outside IDLE. The operands are sampled only on the accept edge.
- busy = (state != IDLE).

## Timing
- Reset values: state = IDLE, out_valid = 0, all flags = 0, busy = 0.
- in_ready is forced to 0 while rst is high and rises in the first cycle after rst deasserts.
- Latency is counted from the accept edge to the first cycle with out_valid = 1. It is k edges:
  - k = N-i when the highest differing bit is bit i.
  - k = N when A == B.
  - Minimum latency is 1 edge, when the MSBs differ.
- Result hold time is unbounded: DONE persists until out_ready is high.
- If out_ready is already high when DONE is entered, out_valid lasts exactly 1 cycle.
- Minimum issue interval is k+2 cycles: accept, k SHIFT cycles, 1 DONE cycle; IDLE is re-entered after that.
- Reset asserted in any state aborts the compare on that edge, returns to the reset values, and produces no out_valid for the aborted pair.
- N = 1: cnt is held at 0, so SHIFT always exits after 1 cycle.
- Output flags are registered, with no combinational path from A or B to the flags. in_ready, out_valid and busy are decoded from the state register only.

## Structure
- Package comparator_pkg:
  - cmp_state_t enum {IDLE, SHIFT, DONE}.
  - Result encoding constants CMP_GT, CMP_LT, CMP_EQ (3-bit one-hot), for reuse by the parallel comparator and by its consumers.
- Sub-module comparator_bit_cell, a 1-bit combinational cell:
  - Inputs a, b.
  - Outputs diff = a^b, gt = a&~b.
  - Instantiated once on the MSBs of sa and sb.
- Top level serial_comparator holds the FSM, shift registers, counter and result registers.

## Test plan
- N=8; A=0x80, B=0x7F -> out_valid 1 edge after accept; A_gt_B=1, others 0.
- N=8; A=0x12, B=0x13 -> out_valid 8 edges after accept; A_lt_B=1.
- N=8; A=B=0xA5 -> out_valid 8 edges after accept; A_eq_B=1. Also run A=B=0x00 and A=B=0xFF with the same expected response.
- Backpressure: out_ready held low for 5 cycles in DONE -> flags and out_valid stable for all 5 cycles. in_valid pulsed during SHIFT and DONE is ignored: in_ready stays 0 and no pair is captured.
- Reset mid-SHIFT (A=0x01, B=0x00, rst high on the 3rd SHIFT cycle) -> next cycle state IDLE, all outputs 0, no out_valid. Next accepted pair A=0x05, B=0x09 -> A_lt_B=1 after 5 edges.
- N=1 build: all four operand pairs {0,0}, {0,1}, {1,0}, {1,1} -> EQ, LT, GT, EQ, each after 1 edge. Back-to-back issue with out_ready tied high -> one result every 3 cycles.
